// File: rtl/uart_frame_rx.sv
// uart_frame_rx: assembles SYNC/LEN/payload/CHK frames from a byte-strobe
// UART receiver, holds a good payload for a consumer, and flags framing errors.
module uart_frame_rx #(
    parameter logic [7:0] c_sync_byte      = 8'hA5,
    parameter int         c_max_len        = 16,
    parameter int         c_timeout_cycles = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_i,
    input  logic       rx_done_tick_i,
    input  logic       frame_ack_i,
    input  logic [3:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic       frame_valid_o,
    output logic [4:0] frame_len_o,
    output logic       chk_err_tick_o,
    output logic       len_err_tick_o,
    output logic       timeout_tick_o,
    output logic       overrun_tick_o
);

    localparam int TW = $clog2(c_timeout_cycles + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(c_timeout_cycles - 1);
    localparam logic [7:0]    MAX_LEN8 = 8'(c_max_len);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    logic [2:0]    state;
    logic [TW-1:0] to_cnt;
    logic [3:0]    wr_idx;
    logic [4:0]    len_q;
    logic [7:0]    chk_q;
    // Sized to the full read address space so any rd_addr_i is in range.
    logic [7:0]    buf_mem [0:15];

    logic in_frame;
    logic to_hit;
    logic wr_en;

    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign to_hit   = in_frame && !rx_done_tick_i && (to_cnt == TO_LAST);
    assign wr_en    = !rst && (state == S_PAYLOAD) && rx_done_tick_i;

    // Inter-byte idle counter, only runs while a frame is partially received.
    always_ff @(posedge clk) begin
        if (rst || !in_frame || rx_done_tick_i || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end

    // Frame FSM, running checksum and one-cycle error strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_HUNT;
            wr_idx         <= '0;
            len_q          <= '0;
            chk_q          <= '0;
            frame_valid_o  <= 1'b0;
            frame_len_o    <= '0;
            chk_err_tick_o <= 1'b0;
            len_err_tick_o <= 1'b0;
            timeout_tick_o <= 1'b0;
            overrun_tick_o <= 1'b0;
        end else begin
            chk_err_tick_o <= 1'b0;
            len_err_tick_o <= 1'b0;
            timeout_tick_o <= 1'b0;
            overrun_tick_o <= 1'b0;
            if (to_hit) begin
                timeout_tick_o <= 1'b1;
                state          <= S_HUNT;
            end else begin
                case (state)
                    S_HUNT: begin
                        if (rx_done_tick_i && din_i == c_sync_byte)
                            state <= S_LEN;
                    end
                    S_LEN: begin
                        if (rx_done_tick_i) begin
                            if (din_i != 8'd0 && din_i <= MAX_LEN8) begin
                                len_q  <= din_i[4:0];
                                chk_q  <= din_i;
                                wr_idx <= '0;
                                state  <= S_PAYLOAD;
                            end else begin
                                len_err_tick_o <= 1'b1;
                                state          <= S_HUNT;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_done_tick_i) begin
                            chk_q  <= chk_q ^ din_i;
                            wr_idx <= wr_idx + 4'd1;
                            if ({1'b0, wr_idx} == len_q - 5'd1)
                                state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (rx_done_tick_i) begin
                            if (din_i == chk_q) begin
                                frame_valid_o <= 1'b1;
                                frame_len_o   <= len_q;
                                state         <= S_HOLD;
                            end else begin
                                chk_err_tick_o <= 1'b1;
                                state          <= S_HUNT;
                            end
                        end
                    end
                    S_HOLD: begin
                        // Payload is frozen; anything arriving now is lost.
                        if (rx_done_tick_i)
                            overrun_tick_o <= 1'b1;
                        if (frame_ack_i) begin
                            frame_valid_o <= 1'b0;
                            state         <= S_HUNT;
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

    // Payload storage; contents survive reset, only the valid flag matters.
    always_ff @(posedge clk) begin
        if (wr_en)
            buf_mem[wr_idx] <= din_i;
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data_o <= '0;
        else
            rd_data_o <= buf_mem[rd_addr_i];
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx (timeout shortened to 50).
module tb_uart_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       tick;
    logic       ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       fvalid;
    logic [4:0] flen;
    logic       chk_err, len_err, to_tick, ovr_tick;

    int checks = 0;
    int errors = 0;
    int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

    uart_frame_rx #(
        .c_sync_byte     (8'hA5),
        .c_max_len       (16),
        .c_timeout_cycles(50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din_i         (din),
        .rx_done_tick_i(tick),
        .frame_ack_i   (ack),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .frame_valid_o (fvalid),
        .frame_len_o   (flen),
        .chk_err_tick_o(chk_err),
        .len_err_tick_o(len_err),
        .timeout_tick_o(to_tick),
        .overrun_tick_o(ovr_tick)
    );

    always #5 clk = ~clk;

    // Strobe tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_err)  n_chk <= n_chk + 1;
        if (len_err)  n_len <= n_len + 1;
        if (to_tick)  n_to  <= n_to + 1;
        if (ovr_tick) n_ovr <= n_ovr + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [159:0] b;     // bytes left-justified, first byte in [159:152]
        int           n;
        bit           v;
        logic [4:0]   len;   // expected frame_len_o after the vector
        int           chk;
        int           lerr;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is always at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        din  = b;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        din  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_list(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[63-8*i -: 8]);
            idle(1);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    int c0, l0, t0, o0;
    int first_to, to_seen;
    logic [7:0] exp_b;

    initial begin
        rst = 1'b1; din = 8'h00; tick = 1'b0; ack = 1'b0; rd_addr = 4'd0;

        // 03^11^22^33 = 03
        tbl[0] = '{b:{48'hA50311223303, 112'd0}, n:6, v:1'b1, len:5'd3, chk:0, lerr:0};
        tbl[1] = '{b:{40'hA5021020FF, 120'd0}, n:5, v:1'b0, len:5'd3, chk:1, lerr:0};
        tbl[2] = '{b:{40'hA502102032, 120'd0}, n:5, v:1'b1, len:5'd2, chk:0, lerr:0};
        tbl[3] = '{b:{40'h00FF5AA500, 120'd0}, n:5, v:1'b0, len:5'd2, chk:0, lerr:1};
        tbl[4] = '{b:{16'hA511, 144'd0}, n:2, v:1'b0, len:5'd2, chk:0, lerr:1};
        // 16-byte payload 00..0F; their XOR is 0 so CHK equals LEN
        tbl[5] = '{b:160'hA510000102030405060708090A0B0C0D0E0F1000, n:19, v:1'b1, len:5'd16, chk:0, lerr:0};
        tbl[6] = '{b:{32'hA501A5A4, 128'd0}, n:4, v:1'b1, len:5'd1, chk:0, lerr:0};

        // Reset state
        idle(3);
        check("rst_valid", 32'(fvalid), 32'd0);
        check("rst_len", 32'(flen), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_strobes", 32'({chk_err, len_err, to_tick, ovr_tick}), 32'd0);
        rst = 1'b0;
        idle(2);

        // Table-driven frames
        for (int k = 0; k < 7; k++) begin
            c0 = n_chk; l0 = n_len; t0 = n_to; o0 = n_ovr;
            for (int i = 0; i < tbl[k].n; i++) begin
                send_byte(tbl[k].b[159-8*i -: 8]);
                idle(1);
            end
            idle(1);
            check($sformatf("v%0d_valid", k), 32'(fvalid), 32'(tbl[k].v));
            check($sformatf("v%0d_len", k), 32'(flen), 32'(tbl[k].len));
            check($sformatf("v%0d_chk_err", k), 32'(n_chk - c0), 32'(tbl[k].chk));
            check($sformatf("v%0d_len_err", k), 32'(n_len - l0), 32'(tbl[k].lerr));
            check($sformatf("v%0d_to_ovr", k), 32'((n_to - t0) + (n_ovr - o0)), 32'd0);
            if (tbl[k].v) begin
                for (int i = 0; i < int'(tbl[k].len); i++) begin
                    rd_addr = 4'(i);
                    @(posedge clk); #1;
                    exp_b = tbl[k].b[159-8*(i+2) -: 8];
                    check($sformatf("v%0d_rd%0d", k, i), 32'(rd_data), 32'(exp_b));
                end
                do_ack();
                check($sformatf("v%0d_ack_low", k), 32'(fvalid), 32'd0);
            end
        end

        // frame_valid_o rises exactly the cycle after the accepting CHK tick
        send_list({32'hA5014445, 32'd0}, 3);
        check("vt_before_chk", 32'(fvalid), 32'd0);
        send_byte(8'h45);
        check("vt_after_chk", 32'(fvalid), 32'd1);
        check("vt_len", 32'(flen), 32'd1);
        do_ack();
        check("vt_ack_low", 32'(fvalid), 32'd0);

        // Timeout: A5 02 10 then silence
        t0 = n_to;
        send_list({24'hA50210, 40'd0}, 2);
        send_byte(8'h10);
        first_to = -1; to_seen = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (to_tick) begin
                to_seen++;
                if (first_to < 0) first_to = i;
            end
        end
        check("to_count", 32'(to_seen), 32'd1);
        check("to_cycle", 32'(first_to), 32'd50);
        send_list({32'hA5014445, 32'd0}, 4);
        check("to_next_valid", 32'(fvalid), 32'd1);
        check("to_next_len", 32'(flen), 32'd1);

        // Overrun while held, then a byte coinciding with ack
        o0 = n_ovr;
        send_byte(8'h77);
        idle(1);
        check("ovr_count", 32'(n_ovr - o0), 32'd1);
        check("ovr_valid", 32'(fvalid), 32'd1);
        rd_addr = 4'd0;
        @(posedge clk); #1;
        check("ovr_buf", 32'(rd_data), 32'h44);
        din = 8'h99; tick = 1'b1; ack = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0; ack = 1'b0; din = 8'h00;
        check("ovr_ack_strobe", 32'(ovr_tick), 32'd1);
        check("ovr_ack_valid", 32'(fvalid), 32'd0);
        idle(1);
        check("ovr_total", 32'(n_ovr - o0), 32'd2);

        // Reset mid-frame; a byte during reset and bytes after it are ignored
        send_list({24'hA50210, 40'd0}, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_valid", 32'(fvalid), 32'd0);
        check("mrst_len", 32'(flen), 32'd0);
        check("mrst_rd_data", 32'(rd_data), 32'd0);
        send_byte(8'hA5);
        rst = 1'b0;
        idle(1);
        c0 = n_chk; l0 = n_len; t0 = n_to; o0 = n_ovr;
        send_list({40'h2030014445, 24'd0}, 5);
        idle(60);
        check("mrst_ignored_valid", 32'(fvalid), 32'd0);
        check("mrst_ignored_strobes", 32'((n_chk - c0) + (n_len - l0) + (n_to - t0) + (n_ovr - o0)), 32'd0);
        send_list({32'hA5014445, 32'd0}, 4);
        check("mrst_next_valid", 32'(fvalid), 32'd1);

        // Reset while holding discards the frame
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("hrst_valid", 32'(fvalid), 32'd0);
        check("hrst_len", 32'(flen), 32'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
